// File: rtl/param_seq_shift_pkg.sv
// Shared definitions for the parametrised sequential shift register:
// operation mode codes, FSM state encoding and a mode-validity helper.
package param_seq_shift_pkg;

  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Codes above ROR are reserved; a start carrying one of them is dropped.
  function automatic logic mode_is_valid(input logic [2:0] m);
    return (m <= MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_step_unit.sv
// One-position shift/rotate datapath. Purely combinational: given the
// current register value it produces the value after a single step and
// the bit that leaves the register on that step.
module shift_step_unit
  import param_seq_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit
);

  // Select the step result for the requested mode; reserved codes hold q.
  always_comb begin
    next_q  = q;
    out_bit = 1'b0;
    case (mode)
      MODE_LSL: begin
        next_q  = {q[WIDTH-2:0], serial_in};
        out_bit = q[WIDTH-1];
      end
      MODE_LSR: begin
        next_q  = {serial_in, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_ASR: begin
        next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_ROL: begin
        next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      MODE_ROR: begin
        next_q  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        next_q  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/param_seq_shift_reg.sv
// Parametrised load/shift/rotate register with a multi-cycle "shift by N"
// operation. A start in IDLE latches mode and count; the register then
// moves one position per clock while busy, and pulses done with the final
// value. A load always wins over a start or a pending step and aborts a
// running operation without a done pulse.
module param_seq_shift_reg
  import param_seq_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             serial_out
);

  state_t           state_reg, state_next;
  logic [2:0]       mode_reg, mode_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             sout_reg, sout_next;

  logic [WIDTH-1:0] step_q;
  logic             step_out;

  // The step unit always works on the latched mode so that mode changes
  // on the input pins during an operation have no effect.
  shift_step_unit #(
    .WIDTH(WIDTH)
  ) u_step (
    .q        (q_reg),
    .mode     (mode_reg),
    .serial_in(serial_in),
    .next_q   (step_q),
    .out_bit  (step_out)
  );

  // Next-state logic: load > start > shift step; done is a one-cycle pulse.
  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    remaining_next = remaining_reg;
    q_next         = q_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    sout_next      = sout_reg;

    if (load) begin
      q_next         = d;
      state_next     = ST_IDLE;
      busy_next      = 1'b0;
      remaining_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start && mode_is_valid(mode)) begin
            if (count == '0) begin
              done_next = 1'b1;
            end else begin
              mode_next      = mode;
              remaining_next = count;
              state_next     = ST_SHIFT;
              busy_next      = 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          q_next         = step_q;
          sout_next      = step_out;
          remaining_next = remaining_reg - CNT_W'(1);
          if (remaining_reg == CNT_W'(1)) begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      mode_reg      <= 3'b000;
      remaining_reg <= '0;
      q_reg         <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      sout_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      remaining_reg <= remaining_next;
      q_reg         <= q_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      sout_reg      <= sout_next;
    end
  end

  assign q          = q_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign serial_out = sout_reg;

endmodule
